stream_merge: RTL and testbench

Two-input round-robin merge for valid/ready streams. It sits directly downstream of the per-core result ports: each core's output stream enters here, and one ordered stream leaves toward the host/collector. Every output word is tagged with its source core. A 2-entry output buffer keeps full throughput while removing any combinational path from `s_ready` to `m*_ready`.

---
 rtl/stream_pkg.sv | 9 +
 rtl/stream_merge_fifo2.sv | 51 +++++
 rtl/stream_merge.sv | 76 +++++++
 tb/tb_stream_merge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and constants for the stream blocks.
// The merge buffer depth and the source tag type live here so neighbours agree on them.
package stream_pkg;

  localparam int MERGE_DEPTH = 2;

  typedef logic [0:0] src_t;

endpackage

// File: rtl/stream_merge_fifo2.sv
// Two-entry FIFO used as the output buffer of stream_merge.
// The caller guarantees no push when full and no pop when empty.
module fifo2
  import stream_pkg::*;
#(
  parameter int width = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic [1:0]       count
);

  logic [width-1:0] mem [MERGE_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  // NOTE: the entries are reset too, so the head reads as zero after reset
  // instead of whatever the storage powered up with.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < MERGE_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here, so every register sees the
      // pre-edge values of the others regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/stream_merge.sv
// Round-robin merge of two valid/ready streams into one tagged stream.
// Input readies depend only on buffer occupancy and input valids, never on s_ready.
module stream_merge
  import stream_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] m0_data,
  input  logic             m0_valid,
  output logic             m0_ready,
  input  logic [width-1:0] m1_data,
  input  logic             m1_valid,
  output logic             m1_ready,
  output logic [width-1:0] s_data,
  output logic             s_src,
  output logic             s_valid,
  input  logic             s_ready
);

  logic [1:0]     count;
  logic           space;
  src_t           grant;
  src_t           prio;
  logic           push;
  logic           pop;
  logic [width:0] push_entry;
  logic [width:0] head_entry;

  assign space = (count < 2'(MERGE_DEPTH));

  // NOTE: grant gets a default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = 1'b0;
    if (m0_valid && m1_valid) begin
      grant = prio;
    end else if (m1_valid) begin
      grant = 1'b1;
    end
  end

  assign m0_ready = ~reset & space & (grant == 1'b0);
  assign m1_ready = ~reset & space & (grant == 1'b1);

  assign push       = (m0_valid & m0_ready) | (m1_valid & m1_ready);
  assign push_entry = {grant, (grant == 1'b1) ? m1_data : m0_data};
  assign pop        = s_valid & s_ready;

  // The loser of this push is preferred next time; idle cycles leave prio alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (push) begin
      prio <= ~grant;
    end
  end

  fifo2 #(
    .width(width + 1)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(head_entry),
    .count    (count)
  );

  assign s_valid = (count != 2'd0);
  assign s_src   = head_entry[width];
  assign s_data  = head_entry[width-1:0];

endmodule

// File: tb/tb_stream_merge.sv
// Directed bench for stream_merge: reset, single source, fairness, full buffer,
// a patterned mixed-traffic run against a small queue model, and mid-flight reset.
module tb_stream_merge;

  logic       clock;
  logic       reset;
  logic [7:0] m0_data;
  logic       m0_valid;
  logic       m0_ready;
  logic [7:0] m1_data;
  logic       m1_valid;
  logic       m1_ready;
  logic [7:0] s_data;
  logic       s_src;
  logic       s_valid;
  logic       s_ready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];
  logic mprio;
  int   n0;
  int   n1;

  stream_merge #(.width(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .m0_data (m0_data),
    .m0_valid(m0_valid),
    .m0_ready(m0_ready),
    .m1_data (m1_data),
    .m1_valid(m1_valid),
    .m1_ready(m1_ready),
    .s_data  (s_data),
    .s_src   (s_src),
    .s_valid (s_valid),
    .s_ready (s_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    m0_data  = 8'h00;
    m1_data  = 8'h00;
    s_ready  = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    check("rst_hold_m0_ready", 32'(m0_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_m0_ready", 32'(m0_ready), 32'd1);
    check("post_rst_m1_ready", 32'(m1_ready), 32'd0);
    check("post_rst_s_valid", 32'(s_valid), 32'd0);
    check("post_rst_s_data", 32'(s_data), 32'd0);
    check("post_rst_s_src", 32'(s_src), 32'd0);
  endtask

  // One cycle of the patterned run: compare against the queue model, then advance it.
  task automatic model_step();
    logic g;
    logic sp;
    logic e0;
    logic e1;
    g  = (m0_valid && m1_valid) ? mprio : m1_valid;
    sp = (q.size() < 2);
    e0 = sp && !g;
    e1 = sp && g;
    check("rnd_m0_ready", 32'(m0_ready), 32'(e0));
    check("rnd_m1_ready", 32'(m1_ready), 32'(e1));
    check("rnd_s_valid", 32'(s_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("rnd_s_src", 32'(s_src), 32'(q[0].src));
      check("rnd_s_data", 32'(s_data), 32'(q[0].data));
      if (s_ready) void'(q.pop_front());
    end
    if (m0_valid && e0) begin
      q.push_back({1'b0, m0_data});
      n0++;
      mprio = 1'b1;
    end else if (m1_valid && e1) begin
      q.push_back({1'b1, m1_data});
      n1++;
      mprio = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] exp_d;
    int         f0;
    int         f1;

    // Reset
    tick();
    apply_reset();

    // Single source: 0x00..0x09 back to back
    s_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      m0_valid = 1'b1;
      m0_data  = 8'(k);
      #1;
      check("single_m0_ready", 32'(m0_ready), 32'd1);
      if (k == 0) begin
        check("single_first_s_valid", 32'(s_valid), 32'd0);
      end else begin
        check("single_s_valid", 32'(s_valid), 32'd1);
        check("single_s_data", 32'(s_data), 32'(k - 1));
        check("single_s_src", 32'(s_src), 32'd0);
      end
      tick();
    end
    m0_valid = 1'b0;
    #1;
    check("single_last_data", 32'(s_data), 32'h09);
    check("single_last_valid", 32'(s_valid), 32'd1);
    tick();
    check("single_empty", 32'(s_valid), 32'd0);

    // Fair conflict, starting from prio = 0
    apply_reset();
    s_ready = 1'b1;
    f0 = 0;
    f1 = 0;
    for (int k = 0; k < 8; k++) begin
      m0_valid = 1'b1;
      m1_valid = 1'b1;
      m0_data  = 8'(8'h10 + f0);
      m1_data  = 8'(8'h80 + f1);
      #1;
      check("fair_m0_ready", 32'(m0_ready), 32'((k % 2) == 0));
      check("fair_m1_ready", 32'(m1_ready), 32'((k % 2) == 1));
      if (k == 0) begin
        check("fair_first_s_valid", 32'(s_valid), 32'd0);
      end else begin
        exp_d = ((k - 1) % 2 == 0) ? 8'(8'h10 + (k - 1) / 2) : 8'(8'h80 + (k - 1) / 2);
        check("fair_s_valid", 32'(s_valid), 32'd1);
        check("fair_s_data", 32'(s_data), 32'(exp_d));
        check("fair_s_src", 32'(s_src), 32'((k - 1) % 2));
      end
      if ((k % 2) == 0) f0++;
      else f1++;
      tick();
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    #1;
    check("fair_tail_data", 32'(s_data), 32'h83);
    check("fair_tail_src", 32'(s_src), 32'd1);
    tick();
    check("fair_empty", 32'(s_valid), 32'd0);

    // Backpressure: prio is 0 here (last push came from core 1)
    s_ready  = 1'b0;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    m0_data  = 8'h20;
    m1_data  = 8'hA0;
    #1;
    check("bp0_m0_ready", 32'(m0_ready), 32'd1);
    check("bp0_m1_ready", 32'(m1_ready), 32'd0);
    tick();
    m0_data = 8'h21;
    #1;
    check("bp1_m0_ready", 32'(m0_ready), 32'd0);
    check("bp1_m1_ready", 32'(m1_ready), 32'd1);
    check("bp1_s_data", 32'(s_data), 32'h20);
    tick();
    m1_data = 8'hA1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("bp_full_m0_ready", 32'(m0_ready), 32'd0);
      check("bp_full_m1_ready", 32'(m1_ready), 32'd0);
      check("bp_full_s_valid", 32'(s_valid), 32'd1);
      check("bp_full_s_data", 32'(s_data), 32'h20);
      tick();
    end
    s_ready = 1'b1;
    #1;
    check("bp_pop_m0_ready", 32'(m0_ready), 32'd0);
    check("bp_pop_m1_ready", 32'(m1_ready), 32'd0);
    check("bp_pop_s_data", 32'(s_data), 32'h20);
    check("bp_pop_s_src", 32'(s_src), 32'd0);
    tick();
    #1;
    check("bp_resume_m0_ready", 32'(m0_ready), 32'd1);
    check("bp_resume_m1_ready", 32'(m1_ready), 32'd0);
    check("bp_drain1_s_data", 32'(s_data), 32'hA0);
    check("bp_drain1_s_src", 32'(s_src), 32'd1);
    tick();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    #1;
    check("bp_drain2_s_data", 32'(s_data), 32'h21);
    check("bp_drain2_s_src", 32'(s_src), 32'd0);
    tick();
    check("bp_empty", 32'(s_valid), 32'd0);

    // Patterned mixed traffic against the queue model
    apply_reset();
    q.delete();
    mprio = 1'b0;
    n0    = 0;
    n1    = 0;
    for (int cnt = 0; cnt < 200; cnt++) begin
      m0_valid = (cnt % 5) != 0;
      m1_valid = (cnt % 3) != 0;
      s_ready  = (cnt % 4) != 0;
      m0_data  = {1'b0, 7'(n0)};
      m1_data  = {1'b1, 7'(n1)};
      #1;
      model_step();
      tick();
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    s_ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      model_step();
      tick();
    end
    check("rnd_drained_s_valid", 32'(s_valid), 32'd0);

    // Mid-flight reset with the buffer full
    apply_reset();
    m0_valid = 1'b1;
    m0_data  = 8'h55;
    tick();
    m0_data = 8'h56;
    tick();
    m0_valid = 1'b0;
    #1;
    check("mid_full_s_valid", 32'(s_valid), 32'd1);
    check("mid_full_m0_ready", 32'(m0_ready), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_s_valid", 32'(s_valid), 32'd0);
    check("mid_rst_m0_ready", 32'(m0_ready), 32'd0);
    #1;
    reset    = 1'b0;
    m0_valid = 1'b1;
    m0_data  = 8'h66;
    s_ready  = 1'b1;
    #1;
    check("mid_after_m0_ready", 32'(m0_ready), 32'd1);
    check("mid_after_s_valid", 32'(s_valid), 32'd0);
    tick();
    m0_valid = 1'b0;
    #1;
    check("mid_new_s_valid", 32'(s_valid), 32'd1);
    check("mid_new_s_data", 32'(s_data), 32'h66);
    check("mid_new_s_src", 32'(s_src), 32'd0);
    tick();
    check("mid_new_empty", 32'(s_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
